// File: rtl/step_clk_ctrl.sv
// ---------------------------------------------------------------------------
// step_clk_ctrl
//
// Produces a single-cycle clock-enable for the pipelined MIPS core from the
// free-running divider bus. Two modes:
//   - manual: one enable pulse per debounced press of the step button
//   - auto:   periodic enable pulses at a switch-selected rate
// A wrapping count of issued pulses is exported for the display.
//
// Parameters
//   DB_BIT     clkdiv bit whose rising edge is the debounce sample tick
//   DB_TICKS   consecutive stable ticks to accept a press or release (1..15)
//   RATE_BASE  clkdiv bit of the fastest auto rate (RATE_BASE+6 <= 31)
//
// Ports
//   clk         system clock (same clock as the divider counter)
//   rst         asynchronous reset, active-high
//   clkdiv      divider count bus, synchronous to clk
//   btn_step    raw step button, asynchronous, active-high
//   sw_auto     raw mode switch, asynchronous; 1 = auto, 0 = manual
//   sel_rate    auto rate select; source bit = RATE_BASE + 2*sel_rate
//   cpu_clk_en  one-clk-wide step enable to the CPU
//   btn_db      debounced button level
//   step_cnt    number of cpu_clk_en pulses issued (wraps)
// ---------------------------------------------------------------------------
module step_clk_ctrl #(
    parameter int DB_BIT    = 16,
    parameter int DB_TICKS  = 4,
    parameter int RATE_BASE = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] clkdiv,
    input  logic        btn_step,
    input  logic        sw_auto,
    input  logic [1:0]  sel_rate,
    output logic        cpu_clk_en,
    output logic        btn_db,
    output logic [15:0] step_cnt
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } state_t;

    // The debounce counter stops one short of DB_TICKS: the tick that finds
    // it at CNT_LAST is the DB_TICKS-th stable tick and causes the move.
    localparam logic [3:0] CNT_LAST = 4'(DB_TICKS - 1);

    // -----------------------------------------------------------------------
    // Two-flop synchronizers: bit 0 = step button, bit 1 = auto switch
    // -----------------------------------------------------------------------
    logic [1:0] raw_in;
    logic [1:0] sync_vec;

    assign raw_in = {sw_auto, btn_step};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= raw_in[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign sync_vec[gi] = sync_reg;
        end
    endgenerate

    logic btn_s;
    logic auto_s;

    assign btn_s  = sync_vec[0];
    assign auto_s = sync_vec[1];

    // -----------------------------------------------------------------------
    // Tick generation: rising edge of a divider bit, one clk wide.
    // Only the currently selected rate bit is kept, so a sel_rate change can
    // produce one spurious or missing rate tick.
    // -----------------------------------------------------------------------
    logic [4:0] rate_idx;
    logic       db_bit_reg;
    logic       rate_bit_reg;
    logic       db_tick;
    logic       rate_tick;

    assign rate_idx  = 5'(RATE_BASE) + {2'b00, sel_rate, 1'b0};
    assign db_tick   = clkdiv[DB_BIT] & ~db_bit_reg;
    assign rate_tick = clkdiv[rate_idx] & ~rate_bit_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_bit_reg   <= 1'b0;
            rate_bit_reg <= 1'b0;
        end else begin
            db_bit_reg   <= clkdiv[DB_BIT];
            rate_bit_reg <= clkdiv[rate_idx];
        end
    end

    // Most divider bits are not needed here; fold them into a named sink.
    logic unused_clkdiv;
    assign unused_clkdiv = ^clkdiv;

    // -----------------------------------------------------------------------
    // Debounce FSM with registered outputs
    // -----------------------------------------------------------------------
    state_t     state_reg;
    logic [3:0] cnt_reg;
    logic       press_evt;
    logic       pulse_next;

    // Level checks win over a same-cycle tick, so a press is accepted only
    // when the button is still high on the final tick.
    assign press_evt  = (state_reg == PRESS_CHK) && btn_s && db_tick &&
                        (cnt_reg == CNT_LAST);
    // Manual presses are ignored in auto mode; mode changes alone never pulse.
    assign pulse_next = auto_s ? rate_tick : press_evt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= 4'd0;
            btn_db     <= 1'b0;
            cpu_clk_en <= 1'b0;
            step_cnt   <= 16'd0;
        end else begin
            cpu_clk_en <= pulse_next;
            if (pulse_next) begin
                step_cnt <= step_cnt + 16'd1;
            end

            case (state_reg)
                IDLE: begin
                    if (btn_s) begin
                        state_reg <= PRESS_CHK;
                        cnt_reg   <= 4'd0;
                    end
                end
                PRESS_CHK: begin
                    if (!btn_s) begin
                        state_reg <= IDLE;
                        cnt_reg   <= 4'd0;
                    end else if (db_tick) begin
                        if (cnt_reg == CNT_LAST) begin
                            state_reg <= HELD;
                            cnt_reg   <= 4'd0;
                            btn_db    <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg + 4'd1;
                        end
                    end
                end
                HELD: begin
                    if (!btn_s) begin
                        state_reg <= REL_CHK;
                        cnt_reg   <= 4'd0;
                    end
                end
                REL_CHK: begin
                    if (btn_s) begin
                        state_reg <= HELD;
                        cnt_reg   <= 4'd0;
                    end else if (db_tick) begin
                        if (cnt_reg == CNT_LAST) begin
                            state_reg <= IDLE;
                            cnt_reg   <= 4'd0;
                            btn_db    <= 1'b0;
                        end else begin
                            cnt_reg <= cnt_reg + 4'd1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= 4'd0;
                    btn_db    <= 1'b0;
                end
            endcase
        end
    end

endmodule
